matrix_nxn_mult_stream: RTL and testbench

- Parametrised successor to the fixed 4x4 fixed-point matrix multiplier.
- Loads A and B as a serial stream of element pairs and computes C = A·B with N parallel MAC lanes.
- Streams C out one row per handshake, with round-to-nearest, saturation and overflow flagging.
- Sits between the element-stream producer and downstream row consumers in the matrix pipeline; ready/valid on both sides.

---
 rtl/matrix_pkg.sv | 63 ++++++
 rtl/matrix_mac_lane.sv | 49 ++++
 rtl/matrix_nxn_mult_stream.sv | 186 ++++++++++++++++++
 tb/tb_matrix_nxn_mult_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and fixed-point helpers for the streaming NxN matrix multiplier.
// Narrowing mode is selected by MATRIX_NXN_SAT_EN in the MAC lane.
package matrix_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StCompute, StOutput} state_e;

    // Widest accumulator the helpers handle; callers pass their real width.
    localparam int unsigned MaxAccW = 64;

    typedef struct packed {
        logic               ovf;
        logic [MaxAccW-1:0] val;
    } fxp_res_t;

    function automatic int unsigned calc_acc_w(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n);
    endfunction

    // Sign-extend from acc_w bits, then round half toward +inf and drop frac bits.
    function automatic logic signed [MaxAccW-1:0] fxp_round(input logic [MaxAccW-1:0] acc,
                                                            input int unsigned frac,
                                                            input int unsigned acc_w);
        logic signed [MaxAccW-1:0] s;
        logic signed [MaxAccW-1:0] half;
        s    = $signed(acc << (MaxAccW - acc_w)) >>> (MaxAccW - acc_w);
        half = $signed(MaxAccW'(1) << (frac - 1));
        return (s + half) >>> frac;
    endfunction

    function automatic fxp_res_t fxp_round_sat(input logic [MaxAccW-1:0] acc,
                                               input int unsigned w,
                                               input int unsigned frac,
                                               input int unsigned acc_w);
        fxp_res_t                  res;
        logic signed [MaxAccW-1:0] r;
        logic signed [MaxAccW-1:0] hi;
        logic signed [MaxAccW-1:0] lo;
        r       = fxp_round(acc, frac, acc_w);
        hi      = $signed((MaxAccW'(1) << (w - 1)) - MaxAccW'(1));
        lo      = ~hi;
        res.ovf = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.ovf = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.ovf = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

    function automatic fxp_res_t fxp_round_wrap(input logic [MaxAccW-1:0] acc,
                                                input int unsigned w,
                                                input int unsigned frac,
                                                input int unsigned acc_w);
        fxp_res_t res;
        res.ovf = 1'b0;
        res.val = fxp_round(acc, frac, acc_w) & ((MaxAccW'(1) << w) - MaxAccW'(1));
        return res;
    endfunction

endpackage

// File: rtl/matrix_mac_lane.sv
// One signed multiply-accumulate lane with clear/enable and rounded W-bit output.
// MATRIX_NXN_SAT_EN selects saturating narrowing; otherwise results wrap.
module matrix_mac_lane
    import matrix_pkg::*;
#(
    parameter int unsigned W    = 12,
    parameter int unsigned FRAC = 10,
    parameter int unsigned AccW = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         ovf
);

    logic signed [2*W-1:0]  prod;
    logic signed [AccW-1:0] acc_q;
    fxp_res_t               rnd;
    logic                   unused_bits;

    assign prod = (2*W)'($signed(a)) * (2*W)'($signed(b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + AccW'(prod);
        end
    end

    always_comb begin
`ifdef MATRIX_NXN_SAT_EN
        rnd = fxp_round_sat(MaxAccW'(acc_q), W, FRAC, AccW);
`else
        rnd = fxp_round_wrap(MaxAccW'(acc_q), W, FRAC, AccW);
`endif
    end

    assign res         = rnd.val[W-1:0];
    assign ovf         = rnd.ovf;
    assign unused_bits = ^rnd.val[MaxAccW-1:W];

endmodule

// File: rtl/matrix_nxn_mult_stream.sv
// Streaming NxN fixed-point matrix multiplier: serial A/B load, N MAC lanes, one C row per beat.
// MATRIX_NXN_SAT_EN enables saturation and the ovf_out flag.
module matrix_nxn_mult_stream
    import matrix_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 12,
    parameter int unsigned FRAC = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [W-1:0]         a_in,
    input  logic [W-1:0]         b_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [N*W-1:0]       c_row,
    output logic [$clog2(N)-1:0] c_row_idx,
    output logic                 last_out,
    output logic                 ovf_out
);

    localparam int unsigned AccW = calc_acc_w(W, N);
    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned KW   = $clog2(N * N);

    state_e          state_q, state_d;
    logic [KW-1:0]   beat_q, beat_d;
    logic [IdxW-1:0] row_q, row_d;
    logic [IdxW-1:0] k_q, k_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [N*W-1:0]  c_row_q, c_row_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            last_q, last_d;
    logic            ovf_q, ovf_d;

    logic            wr_en, mac_clr, mac_en;
    logic [W-1:0]    a_mem [N*N];
    logic [W-1:0]    b_mem [N*N];
    logic [KW-1:0]   a_idx;
    logic [N*W-1:0]  lane_flat;
    logic [N-1:0]    lane_ovf;

    // Element storage has no reset: contents are don't-care until reloaded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            a_mem[beat_q] <= a_in;
            b_mem[beat_q] <= b_in;
        end
    end

    assign a_idx = KW'(row_q) * KW'(N) + KW'(k_q);

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [KW-1:0] b_idx;
        assign b_idx = KW'(k_q) * KW'(N) + KW'(j);

        matrix_mac_lane #(
            .W    (W),
            .FRAC (FRAC),
            .AccW (AccW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (mac_clr),
            .en    (mac_en),
            .a     (a_mem[a_idx]),
            .b     (b_mem[b_idx]),
            .res   (lane_flat[j*W +: W]),
            .ovf   (lane_ovf[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            row_q   <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            c_row_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            k_q     <= k_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            c_row_q <= c_row_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        row_d   = row_q;
        k_d     = k_q;
        done_d  = done_q;
        ready_d = ready_q;
        valid_d = valid_q;
        c_row_d = c_row_q;
        idx_d   = idx_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StLoad;
                ready_d = 1'b1;
                beat_d  = '0;
            end
            StLoad: begin
                if (valid_in && ready_q) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == KW'(N * N - 1)) begin
                        state_d = StCompute;
                        ready_d = 1'b0;
                        beat_d  = '0;
                        row_d   = '0;
                        k_d     = '0;
                        done_d  = 1'b0;
                        mac_clr = 1'b1;
                    end
                end
            end
            StCompute: begin
                // N MAC cycles, then one cycle to capture the narrowed row.
                if (!done_q) begin
                    mac_en = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (k_q == IdxW'(N - 1)) begin
                        done_d = 1'b1;
                        k_d    = '0;
                    end
                end else begin
                    state_d = StOutput;
                    valid_d = 1'b1;
                    c_row_d = lane_flat;
                    idx_d   = row_q;
                    last_d  = (row_q == IdxW'(N - 1));
                    ovf_d   = |lane_ovf;
                end
            end
            StOutput: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    if (row_q != IdxW'(N - 1)) begin
                        state_d = StCompute;
                        row_d   = row_q + 1'b1;
                        k_d     = '0;
                        done_d  = 1'b0;
                        mac_clr = 1'b1;
                    end else begin
                        state_d = StLoad;
                        ready_d = 1'b1;
                        row_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign c_row     = c_row_q;
    assign c_row_idx = idx_q;
    assign last_out  = last_q;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_matrix_nxn_mult_stream.sv
// Directed self-checking bench: identity, saturation, rounding, backpressure, mid-run reset, N=2.
module tb_matrix_nxn_mult_stream;

    localparam int N = 4;
    localparam int W = 12;

`ifdef MATRIX_NXN_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           valid_in = 1'b0;
    logic           ready_out;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           valid_out;
    logic           ready_in = 1'b0;
    logic [N*W-1:0] c_row;
    logic [1:0]     c_row_idx;
    logic           last_out;
    logic           ovf_out;

    logic           valid_in2 = 1'b0;
    logic           ready_out2;
    logic [W-1:0]   a_in2 = '0;
    logic [W-1:0]   b_in2 = '0;
    logic           valid_out2;
    logic           ready_in2 = 1'b0;
    logic [2*W-1:0] c_row2;
    logic [0:0]     c_row_idx2;
    logic           last_out2;
    logic           ovf_out2;

    always #5 clk = ~clk;

    matrix_nxn_mult_stream #(.N(4), .W(12), .FRAC(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .a_in      (a_in),
        .b_in      (b_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .c_row     (c_row),
        .c_row_idx (c_row_idx),
        .last_out  (last_out),
        .ovf_out   (ovf_out)
    );

    matrix_nxn_mult_stream #(.N(2), .W(12), .FRAC(10)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in2),
        .ready_out (ready_out2),
        .a_in      (a_in2),
        .b_in      (b_in2),
        .valid_out (valid_out2),
        .ready_in  (ready_in2),
        .c_row     (c_row2),
        .c_row_idx (c_row_idx2),
        .last_out  (last_out2),
        .ovf_out   (ovf_out2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] ma [16];
    logic [W-1:0] mb [16];
    logic [W-1:0] mc [16];
    logic         row_ovf [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_matrix(input string tag);
        for (int k = 0; k < 16; k++) begin
            int waited = 0;
            a_in     = ma[k];
            b_in     = mb[k];
            valid_in = 1'b1;
            while (!ready_out && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!ready_out) check_eq({tag, "_load_ready"}, 64'(ready_out), 64'(1));
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (!valid_out && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic read_rows(input string tag, input int stall_row);
        logic [N*W-1:0] exp_row;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) exp_row[j*W +: W] = mc[r*4 + j];
            wait_valid(tag, N + 1);
            check_eq({tag, "_row"}, 64'(c_row), 64'(exp_row));
            check_eq({tag, "_idx"}, 64'(c_row_idx), 64'(r));
            check_eq({tag, "_last"}, 64'(last_out), 64'(r == 3));
            check_eq({tag, "_ovf"}, 64'(ovf_out), 64'(row_ovf[r]));
            if (r == stall_row) begin
                repeat (7) begin
                    @(posedge clk); #1;
                    check_eq({tag, "_stall_valid"}, 64'(valid_out), 64'(1));
                    check_eq({tag, "_stall_row"}, 64'(c_row), 64'(exp_row));
                end
            end
            ready_in = 1'b1;
            @(posedge clk); #1;
            ready_in = 1'b0;
            check_eq({tag, "_valid_drop"}, 64'(valid_out), 64'(0));
        end
        check_eq({tag, "_ready_after_last"}, 64'(ready_out), 64'(1));
    endtask

    // B used against the identity matrix; C must equal it exactly.
    localparam logic [16*W-1:0] BId = {
        12'h678, 12'h345, 12'h012, 12'hFED,
        12'h100, 12'h000, 12'h5A5, 12'hA5A,
        12'h004, 12'h003, 12'h002, 12'h001,
        12'h7FF, 12'h800, 12'hFFF, 12'h123
    };

    task automatic set_identity();
        logic [16*W-1:0] bv;
        bv = BId;
        for (int k = 0; k < 16; k++) begin
            ma[k] = (k / 4 == k % 4) ? 12'h400 : 12'h000;
            mb[k] = bv[k*W +: W];
            mc[k] = bv[k*W +: W];
        end
        for (int r = 0; r < 4; r++) row_ovf[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check_eq("rst_ready", 64'(ready_out), 64'(0));
        check_eq("rst_valid", 64'(valid_out), 64'(0));
        check_eq("rst_crow", 64'(c_row), 64'(0));
        check_eq("rst_idx", 64'(c_row_idx), 64'(0));
        check_eq("rst_last", 64'(last_out), 64'(0));
        check_eq("rst_ovf", 64'(ovf_out), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst_ready_pre_edge", 64'(ready_out), 64'(0));
        @(posedge clk); #1;
        check_eq("ready_rise", 64'(ready_out), 64'(1));

        // Identity times B
        set_identity();
        load_matrix("ident");
        read_rows("ident", -1);

        // Saturation, with a 7-cycle stall on row 2
        for (int k = 0; k < 16; k++) begin
            ma[k] = 12'h7FF;
            mb[k] = 12'h7FF;
            mc[k] = SatEn ? 12'h7FF : 12'hFF0;
        end
        for (int r = 0; r < 4; r++) row_ovf[r] = SatEn;
        load_matrix("sat");
        read_rows("sat", 2);

        // Reset while row 1 is presented
        set_identity();
        load_matrix("mid");
        wait_valid("mid_r0", N + 1);
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        wait_valid("mid_r1", N + 1);
        check_eq("mid_pre_idx", 64'(c_row_idx), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(valid_out), 64'(0));
        check_eq("mid_rst_ready", 64'(ready_out), 64'(0));
        check_eq("mid_rst_crow", 64'(c_row), 64'(0));
        check_eq("mid_rst_idx", 64'(c_row_idx), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_ready_rise", 64'(ready_out), 64'(1));

        // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds to zero
        for (int k = 0; k < 16; k++) begin
            ma[k] = 12'h000;
            mb[k] = 12'h000;
            mc[k] = 12'h000;
        end
        ma[0] = 12'h200;
        ma[4] = 12'hE00;
        mb[0] = 12'h001;
        mc[0] = 12'h001;
        for (int r = 0; r < 4; r++) row_ovf[r] = 1'b0;
        load_matrix("round");
        read_rows("round", -1);

        // N=2 instance
        begin
            logic [W-1:0] a2 [4];
            logic [W-1:0] b2 [4];
            int lat;
            a2 = '{12'h400, 12'h400, 12'h000, 12'h400};
            b2 = '{12'h400, 12'h000, 12'h400, 12'h400};
            for (int k = 0; k < 4; k++) begin
                int waited = 0;
                a_in2 = a2[k];
                b_in2 = b2[k];
                valid_in2 = 1'b1;
                while (!ready_out2 && waited < 20) begin
                    @(posedge clk); #1;
                    waited++;
                end
                if (!ready_out2) check_eq("n2_load_ready", 64'(ready_out2), 64'(1));
                @(posedge clk); #1;
            end
            valid_in2 = 1'b0;
            for (int r = 0; r < 2; r++) begin
                lat = 0;
                while (!valid_out2 && lat < 50) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check_eq("n2_lat", 64'(lat), 64'(3));
                if (r == 0) begin
                    check_eq("n2_row0", 64'(c_row2),
                             64'({12'h400, (SatEn ? 12'h7FF : 12'h800)}));
                    check_eq("n2_ovf0", 64'(ovf_out2), 64'(SatEn));
                end else begin
                    check_eq("n2_row1", 64'(c_row2), 64'({12'h400, 12'h400}));
                    check_eq("n2_ovf1", 64'(ovf_out2), 64'(0));
                end
                check_eq("n2_idx", 64'(c_row_idx2), 64'(r));
                check_eq("n2_last", 64'(last_out2), 64'(r == 1));
                ready_in2 = 1'b1;
                @(posedge clk); #1;
                ready_in2 = 1'b0;
            end
            check_eq("n2_ready_after_last", 64'(ready_out2), 64'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
